// File: rtl/grey_code_pkg.sv
// Shared sizing and state type for the round-robin binary-to-Gray arbiter.
package grey_code_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : grey_code_pkg

// File: rtl/grey_code.sv
// 4-bit binary to Gray converter; A is the binary MSB.
module grey_code (
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic [3:0] F
);

    assign F = {A, A ^ B, B ^ C, C ^ D};

endmodule : grey_code

// File: rtl/grey_code_arbiter.sv
// Round-robin arbiter capturing one requester's binary word and presenting
// its Gray code on a valid/ready output, re-arbitrating on the handshake.
module grey_code_arbiter #(
    parameter int unsigned N_REQ = grey_code_pkg::N_REQ,
    parameter int unsigned WIDTH = grey_code_pkg::WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*WIDTH-1:0]        din,
    output logic [N_REQ-1:0]              gnt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_code,
    output logic [grey_code_pkg::ID_W-1:0] out_id
);

    import grey_code_pkg::*;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic               valid_nxt;
    logic [WIDTH-1:0]   cap_word, word_nxt;
    logic [ID_W-1:0]    id_nxt;

    logic               handshake;
    logic [ID_W-1:0]    arb_ptr;
    logic [N_REQ-1:0]   arb_mask;
    logic [ID_W:0]      pick;
    logic               pick_hit;
    logic [ID_W-1:0]    pick_idx;

    // First unmasked requester at or after p, wrapping; returns {hit, index}.
    function automatic logic [ID_W:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [N_REQ-1:0] m,
        input logic [ID_W-1:0]  p
    );
        logic            hit;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        hit = 1'b0;
        win = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'(32'(p) + k);
            if (!hit && r[idx] && !m[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        return {hit, win};
    endfunction

    assign handshake = out_valid && out_ready;
    assign pick_hit  = pick[ID_W];
    assign pick_idx  = pick[ID_W-1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        valid_nxt = out_valid;
        word_nxt  = cap_word;
        id_nxt    = out_id;
        arb_ptr   = ptr;
        arb_mask  = '0;

        // The word being handed off must not win its own replacement slot.
        if (state == BUSY && handshake) begin
            arb_ptr  = ID_W'(out_id + 1'b1);
            arb_mask = N_REQ'(1) << out_id;
        end

        pick = rr_pick(req, arb_mask, arb_ptr);

        case (state)
            IDLE: begin
                if (pick_hit) begin
                    word_nxt  = din[32'(pick_idx)*WIDTH +: WIDTH];
                    id_nxt    = pick_idx;
                    gnt_nxt   = N_REQ'(1) << pick_idx;
                    valid_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (handshake) begin
                    ptr_nxt = arb_ptr;
                    if (pick_hit) begin
                        word_nxt = din[32'(pick_idx)*WIDTH +: WIDTH];
                        id_nxt   = pick_idx;
                        gnt_nxt  = N_REQ'(1) << pick_idx;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any capture or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            cap_word  <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            out_valid <= valid_nxt;
            cap_word  <= word_nxt;
            out_id    <= id_nxt;
        end
    end

    grey_code u_conv (
        .A (cap_word[3]),
        .B (cap_word[2]),
        .C (cap_word[1]),
        .D (cap_word[0]),
        .F (out_code)
    );

endmodule : grey_code_arbiter
